de_stage: RTL and testbench

DE_STAGE -- requirements
Module: de_stage

---
 rtl/de_stage_pkg.sv | 99 +++++++++
 rtl/de_regfile.sv | 46 ++++
 rtl/de_stage.sv | 177 +++++++++++++++++
 tb/tb_de_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/de_stage_pkg.sv
// Decode-stage shared definitions: latch layouts, op enumeration, opcode values,
// instruction field positions and immediate helpers used by de_stage and de_regfile.
// No logic of its own; the optional bypass (DE_WB_BYPASS_EN) lives in the modules.
package de_stage_pkg;

    localparam int XLEN         = 32;
    localparam int NUM_REGS     = 32;
    localparam int REG_IDX_W    = 5;
    localparam int CANARY_WIDTH = 8;

    localparam logic [CANARY_WIDTH-1:0] BUS_CANARY_VALUE = 8'hA5;

    localparam int INST_RD_LSB  = 7;
    localparam int INST_RS1_LSB = 15;
    localparam int INST_RS2_LSB = 20;

    typedef enum logic [5:0] {
        OP_NONE    = 6'd0,
        OP_LUI     = 6'd1,
        OP_AUIPC   = 6'd2,
        OP_JAL     = 6'd3,
        OP_JALR    = 6'd4,
        OP_BRANCH  = 6'd5,
        OP_LOAD    = 6'd6,
        OP_STORE   = 6'd7,
        OP_OPIMM   = 6'd8,
        OP_OP      = 6'd9,
        OP_ILLEGAL = 6'd63
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0]         inst;
        logic [XLEN-1:0]         pc;
        logic [XLEN-1:0]         pcplus;
        logic [XLEN-1:0]         inst_count;
        logic [CANARY_WIDTH-1:0] canary;
    } fe_latch_t;

    typedef struct packed {
        logic                 wr_en;
        logic [REG_IDX_W-1:0] wr_rd;
        logic [XLEN-1:0]      wr_data;
    } wb_to_de_t;

    typedef struct packed {
        logic                    valid;
        op_e                     op;
        logic [REG_IDX_W-1:0]    rd;
        logic                    wr_reg;
        logic [XLEN-1:0]         rs1_val;
        logic [XLEN-1:0]         rs2_val;
        logic [XLEN-1:0]         imm;
        logic [XLEN-1:0]         pc;
        logic [XLEN-1:0]         pcplus;
        logic [XLEN-1:0]         inst_count;
        logic [CANARY_WIDTH-1:0] canary;
    } de_latch_t;

    localparam int FE_LATCH_WIDTH   = $bits(fe_latch_t);
    localparam int AGEX_TO_DE_WIDTH = 1;
    localparam int WB_TO_DE_WIDTH   = $bits(wb_to_de_t);
    localparam int DE_TO_FE_WIDTH   = 1;
    localparam int DE_LATCH_WIDTH   = $bits(de_latch_t);

    function automatic logic [REG_IDX_W-1:0] reg_field(input logic [XLEN-1:0] inst, input int lsb);
        return inst[lsb +: REG_IDX_W];
    endfunction

    function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [XLEN-1:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [XLEN-1:0] i);
        return {i[31:12], 12'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/de_regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 hard-wired to 0.
// Latency: reads 0 cycles, writes visible next cycle; no backpressure.
// With DE_WB_BYPASS_EN a same-cycle write is forwarded onto a matching read port.
module de_regfile
    import de_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_rd,
    input  logic [XLEN-1:0]      wr_data,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic [XLEN-1:0]      rs1_val,
    output logic [XLEN-1:0]      rs2_val
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (wr_en && (wr_rd != '0)) begin
            regs[wr_rd] <= wr_data;
        end
    end

    always_comb begin
        rs1_val = (rs1 == '0) ? '0 : regs[rs1];
`ifdef DE_WB_BYPASS_EN
        if (wr_en && (rs1 != '0) && (wr_rd == rs1)) begin
            rs1_val = wr_data;
        end
`endif
    end

    always_comb begin
        rs2_val = (rs2 == '0) ? '0 : regs[rs2];
`ifdef DE_WB_BYPASS_EN
        if (wr_en && (rs2 != '0) && (wr_rd == rs2)) begin
            rs2_val = wr_data;
        end
`endif
    end

endmodule

// File: rtl/de_stage.sv
// RV32I decode stage: decode, register read, per-register pending scoreboard, DE latch.
// Latency 1 cycle FE->DE latch; RAW hazards stall FE combinationally, br_flush overrides.
// DE_WB_BYPASS_EN: forward a same-cycle WB write and skip the stall it would resolve.
module de_stage
    import de_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [FE_LATCH_WIDTH-1:0]   from_FE_latch,
    input  logic [AGEX_TO_DE_WIDTH-1:0] from_AGEX_to_DE,
    input  logic [WB_TO_DE_WIDTH-1:0]   from_WB_to_DE,
    output logic [DE_TO_FE_WIDTH-1:0]   from_DE_to_FE,
    output logic [DE_LATCH_WIDTH-1:0]   DE_latch_out
);

    fe_latch_t fe;
    wb_to_de_t wb;
    logic      br_flush;

    assign fe       = fe_latch_t'(from_FE_latch);
    assign wb       = wb_to_de_t'(from_WB_to_DE);
    assign br_flush = from_AGEX_to_DE[0];

    logic [6:0]           opcode;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 bubble;

    assign opcode = fe.inst[6:0];
    assign rd     = reg_field(fe.inst, INST_RD_LSB);
    assign rs1    = reg_field(fe.inst, INST_RS1_LSB);
    assign rs2    = reg_field(fe.inst, INST_RS2_LSB);
    assign bubble = (fe.inst == '0);

    op_e             dec_op;
    logic            dec_wr;
    logic            use_rs1;
    logic            use_rs2;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_op  = OP_ILLEGAL;
        dec_wr  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dec_imm = '0;
        case (opcode)
            OPC_LUI:    begin dec_op = OP_LUI;    dec_wr = 1'b1; dec_imm = imm_u(fe.inst); end
            OPC_AUIPC:  begin dec_op = OP_AUIPC;  dec_wr = 1'b1; dec_imm = imm_u(fe.inst); end
            OPC_JAL:    begin dec_op = OP_JAL;    dec_wr = 1'b1; dec_imm = imm_j(fe.inst); end
            OPC_JALR:   begin
                dec_op = OP_JALR; dec_wr = 1'b1; use_rs1 = 1'b1; dec_imm = imm_i(fe.inst);
            end
            OPC_BRANCH: begin
                dec_op = OP_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm = imm_b(fe.inst);
            end
            OPC_LOAD:   begin
                dec_op = OP_LOAD; dec_wr = 1'b1; use_rs1 = 1'b1; dec_imm = imm_i(fe.inst);
            end
            OPC_STORE:  begin
                dec_op = OP_STORE; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm = imm_s(fe.inst);
            end
            OPC_OPIMM:  begin
                dec_op = OP_OPIMM; dec_wr = 1'b1; use_rs1 = 1'b1; dec_imm = imm_i(fe.inst);
            end
            OPC_OP:     begin
                dec_op = OP_OP; dec_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] rf_rs1_val;
    logic [XLEN-1:0] rf_rs2_val;

    de_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wb.wr_en),
        .wr_rd   (wb.wr_rd),
        .wr_data (wb.wr_data),
        .rs1     (rs1),
        .rs2     (rs2),
        .rs1_val (rf_rs1_val),
        .rs2_val (rf_rs2_val)
    );

    logic [1:0] pending [NUM_REGS];
    logic       byp1;
    logic       byp2;

    // A WB write only clears the hazard if it retires the last outstanding producer.
`ifdef DE_WB_BYPASS_EN
    assign byp1 = wb.wr_en && (wb.wr_rd == rs1) && (pending[rs1] == 2'd1);
    assign byp2 = wb.wr_en && (wb.wr_rd == rs2) && (pending[rs2] == 2'd1);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    logic haz1;
    logic haz2;
    logic stall_raw;
    logic issue;
    logic cnt_inc;

    assign haz1      = use_rs1 && (rs1 != '0) && (pending[rs1] != 2'd0) && !byp1;
    assign haz2      = use_rs2 && (rs2 != '0) && (pending[rs2] != 2'd0) && !byp2;
    assign stall_raw = !bubble && (haz1 || haz2);
    assign issue     = !bubble && !stall_raw && !br_flush;
    assign cnt_inc   = issue && dec_wr && (rd != '0);

    assign from_DE_to_FE = stall_raw && !br_flush && !reset;

    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (cnt_inc) begin
            inc_vec[rd] = 1'b1;
        end
        if (wb.wr_en) begin
            dec_vec[wb.wr_rd] = 1'b1;
        end
    end

    // x0 never increments, so its counter stays pinned at 0 by the floor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '{default: '0};
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r] && (pending[r] != 2'd3)) begin
                    pending[r] <= pending[r] + 2'd1;
                end else if (dec_vec[r] && !inc_vec[r] && (pending[r] != 2'd0)) begin
                    pending[r] <= pending[r] - 2'd1;
                end
            end
        end
    end

    de_latch_t de_next;
    de_latch_t de_q;

    // Bubbles carry the bus canary constant; real instructions carry FE's canary through.
    always_comb begin
        de_next        = '0;
        de_next.canary = BUS_CANARY_VALUE;
        if (issue) begin
            de_next.valid      = 1'b1;
            de_next.op         = dec_op;
            de_next.rd         = dec_wr ? rd : '0;
            de_next.wr_reg     = dec_wr;
            de_next.rs1_val    = use_rs1 ? rf_rs1_val : '0;
            de_next.rs2_val    = use_rs2 ? rf_rs2_val : '0;
            de_next.imm        = dec_imm;
            de_next.pc         = fe.pc;
            de_next.pcplus     = fe.pcplus;
            de_next.inst_count = fe.inst_count;
            de_next.canary     = fe.canary;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q <= '0;
        end else begin
            de_q <= de_next;
        end
    end

    assign DE_latch_out = de_q;

endmodule

// File: tb/tb_de_stage.sv
// Self-checking bench for de_stage: directed hazard/flush/reset scenarios, then randomized
// instruction streams with a queue-driven WB model and a reference scoreboard.
module tb_de_stage;
    import de_stage_pkg::*;

`ifdef DE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        reset;
    logic [FE_LATCH_WIDTH-1:0]   from_FE_latch;
    logic [AGEX_TO_DE_WIDTH-1:0] from_AGEX_to_DE;
    logic [WB_TO_DE_WIDTH-1:0]   from_WB_to_DE;
    logic [DE_TO_FE_WIDTH-1:0]   from_DE_to_FE;
    logic [DE_LATCH_WIDTH-1:0]   DE_latch_out;

    always #5 clk = ~clk;

    de_stage dut (
        .clk             (clk),
        .reset           (reset),
        .from_FE_latch   (from_FE_latch),
        .from_AGEX_to_DE (from_AGEX_to_DE),
        .from_WB_to_DE   (from_WB_to_DE),
        .from_DE_to_FE   (from_DE_to_FE),
        .DE_latch_out    (DE_latch_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [32];
    int          m_pend [32];

    typedef struct packed {
        op_e         op;
        logic        wr;
        logic        u1;
        logic        u2;
        logic [31:0] imm;
    } ref_dec_t;

    typedef struct {
        logic [4:0] rd;
        int         due;
    } wb_ent_t;

    wb_ent_t   wbq [$];
    de_latch_t lat;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ref_dec_t ref_decode(input logic [31:0] inst);
        ref_dec_t d;
        int       v;
        d.op = OP_ILLEGAL; d.wr = 1'b0; d.u1 = 1'b0; d.u2 = 1'b0; d.imm = 32'h0;
        case (inst[6:0])
            7'h37: begin d.op = OP_LUI;   d.wr = 1'b1; d.imm = inst & 32'hFFFF_F000; end
            7'h17: begin d.op = OP_AUIPC; d.wr = 1'b1; d.imm = inst & 32'hFFFF_F000; end
            7'h6F: begin
                d.op = OP_JAL; d.wr = 1'b1;
                v = (inst[31] ? -1048576 : 0) + int'(inst[19:12]) * 4096
                    + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
                d.imm = 32'(v);
            end
            7'h67: begin d.op = OP_JALR; d.wr = 1'b1; d.u1 = 1'b1; d.imm = 32'($signed(inst) >>> 20); end
            7'h63: begin
                d.op = OP_BRANCH; d.u1 = 1'b1; d.u2 = 1'b1;
                v = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048
                    + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
                d.imm = 32'(v);
            end
            7'h03: begin d.op = OP_LOAD; d.wr = 1'b1; d.u1 = 1'b1; d.imm = 32'($signed(inst) >>> 20); end
            7'h23: begin
                d.op = OP_STORE; d.u1 = 1'b1; d.u2 = 1'b1;
                d.imm = (32'($signed(inst) >>> 25) << 5) | 32'(inst[11:7]);
            end
            7'h13: begin d.op = OP_OPIMM; d.wr = 1'b1; d.u1 = 1'b1; d.imm = 32'($signed(inst) >>> 20); end
            7'h33: begin d.op = OP_OP; d.wr = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic bit src_blocked(input logic [4:0] s, input bit we, input logic [4:0] wrd);
        if (s == 5'd0 || m_pend[s] == 0) return 1'b0;
        if (BYPASS && we && wrd == s && m_pend[s] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] src_val(input logic [4:0] s, input bit we,
                                            input logic [4:0] wrd, input logic [31:0] wdat);
        if (s == 5'd0) return 32'h0;
        if (BYPASS && we && wrd == s) return wdat;
        return m_regs[s];
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'h0;
            m_pend[r] = 0;
        end
        wbq.delete();
    endtask

    // One FE presentation: drive at negedge, check stall, clock, check latch, advance model.
    task automatic cycle(input logic [31:0] inst, input bit flush, input bit we,
                         input logic [4:0] wrd, input logic [31:0] wdat,
                         output bit stalled, output bit issued, output logic [4:0] ird);
        fe_latch_t  fe;
        wb_to_de_t  wb;
        ref_dec_t   d;
        de_latch_t  exp;
        bit         haz;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [4:0] rd;
        @(negedge clk);
        fe.inst = inst; fe.pc = $urandom; fe.pcplus = fe.pc + 32'd4;
        fe.inst_count = $urandom; fe.canary = 8'($urandom);
        wb.wr_en = we; wb.wr_rd = wrd; wb.wr_data = wdat;
        from_FE_latch   = fe;
        from_AGEX_to_DE = flush;
        from_WB_to_DE   = wb;
        #1;
        d  = ref_decode(inst);
        s1 = inst[19:15];
        s2 = inst[24:20];
        haz = (inst != 32'h0) && ((d.u1 && src_blocked(s1, we, wrd)) || (d.u2 && src_blocked(s2, we, wrd)));
        stalled = haz && !flush;
        check("stall", from_DE_to_FE, stalled);
        issued = (inst != 32'h0) && !flush && !haz;
        exp = '0;
        exp.canary = BUS_CANARY_VALUE;
        if (issued) begin
            exp.valid      = 1'b1;
            exp.op         = d.op;
            exp.wr_reg     = d.wr;
            exp.rd         = d.wr ? inst[11:7] : 5'd0;
            exp.rs1_val    = d.u1 ? src_val(s1, we, wrd, wdat) : 32'h0;
            exp.rs2_val    = d.u2 ? src_val(s2, we, wrd, wdat) : 32'h0;
            exp.imm        = d.imm;
            exp.pc         = fe.pc;
            exp.pcplus     = fe.pcplus;
            exp.inst_count = fe.inst_count;
            exp.canary     = fe.canary;
        end
        @(posedge clk);
        #1;
        check("de_latch", DE_latch_out, exp);
        rd = exp.rd;
        if (we && wrd != 5'd0) m_regs[wrd] = wdat;
        for (int r = 1; r < 32; r++) begin
            bit inc;
            bit dec;
            inc = issued && d.wr && (rd == 5'(r));
            dec = we && (wrd == 5'(r));
            if (inc && !dec && m_pend[r] < 3) m_pend[r]++;
            else if (dec && !inc && m_pend[r] > 0) m_pend[r]--;
        end
        ird = (issued && d.wr) ? rd : 5'd0;
    endtask

    task automatic reset_now();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_stall", from_DE_to_FE, 0);
        check("rst_latch", DE_latch_out, 0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 15) == 0) return 32'h0;
        case ($urandom_range(0, 10))
            0: r[6:0] = 7'h37;
            1: r[6:0] = 7'h17;
            2: r[6:0] = 7'h6F;
            3: r[6:0] = 7'h67;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h03;
            6: r[6:0] = 7'h23;
            7: r[6:0] = 7'h13;
            8: r[6:0] = 7'h33;
            9: r[6:0] = 7'h0F;
            default: r[6:0] = 7'h7F;
        endcase
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] ADD_X2_X1  = 32'h0010_8133;
    localparam logic [31:0] ADDI_X3_1  = 32'h0010_0193;
    localparam logic [31:0] ADD_X4_X3  = 32'h0001_8233;
    localparam logic [31:0] ADDI_X5_5  = 32'h0050_0293;
    localparam logic [31:0] ADD_X6_X5  = 32'h0002_8333;
    localparam logic [31:0] ADD_X8_X0  = 32'h0000_0433;

    initial begin
        bit          st;
        bit          is;
        logic [4:0]  ird;
        logic [31:0] cur;
        bit          we;
        bit          fl;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        int          k;

        reset = 1'b1;
        from_FE_latch = '0;
        from_AGEX_to_DE = '0;
        from_WB_to_DE = '0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check("init_stall", from_DE_to_FE, 0);
        check("init_latch", DE_latch_out, 0);
        @(negedge clk);
        reset = 1'b0;

        cycle(ADDI_X1_5, 0, 0, 5'd0, 32'h0, st, is, ird);
        lat = de_latch_t'(DE_latch_out);
        check("addi_valid", lat.valid, 1);
        check("addi_op", lat.op, OP_OPIMM);
        check("addi_rd", lat.rd, 1);
        check("addi_imm", lat.imm, 5);

        cycle(ADD_X2_X1, 0, 0, 5'd0, 32'h0, st, is, ird);
        cycle(ADD_X2_X1, 0, 1, 5'd1, 32'd5, st, is, ird);
        k = 0;
        while (st && k < 4) begin
            cycle(ADD_X2_X1, 0, 0, 5'd0, 32'h0, st, is, ird);
            k++;
        end
        lat = de_latch_t'(DE_latch_out);
        check("raw_rs1", lat.rs1_val, 5);
        check("raw_rs2", lat.rs2_val, 5);

        cycle(ADDI_X3_1, 0, 0, 5'd0, 32'h0, st, is, ird);
        cycle(ADD_X4_X3, 0, 1, 5'd3, 32'hDEAD, st, is, ird);
        if (st) cycle(ADD_X4_X3, 0, 0, 5'd0, 32'h0, st, is, ird);
        lat = de_latch_t'(DE_latch_out);
        check("wb_fwd_rs1", lat.rs1_val, 32'hDEAD);

        cycle(ADDI_X5_5, 0, 0, 5'd0, 32'h0, st, is, ird);
        cycle(ADDI_X5_5, 0, 0, 5'd0, 32'h0, st, is, ird);
        cycle(ADD_X6_X5, 0, 0, 5'd0, 32'h0, st, is, ird);
        cycle(ADD_X6_X5, 1, 0, 5'd0, 32'h0, st, is, ird);
        lat = de_latch_t'(DE_latch_out);
        check("flush_valid", lat.valid, 0);
        cycle(ADD_X6_X5, 0, 0, 5'd0, 32'h0, st, is, ird);
        reset_now();
        cycle(ADD_X6_X5, 0, 0, 5'd0, 32'h0, st, is, ird);
        lat = de_latch_t'(DE_latch_out);
        check("post_rst_valid", lat.valid, 1);

        cycle(ADD_X8_X0, 0, 1, 5'd0, 32'hFFFF_FFFF, st, is, ird);
        cycle(ADD_X8_X0, 0, 0, 5'd0, 32'h0, st, is, ird);
        lat = de_latch_t'(DE_latch_out);
        check("x0_rs1", lat.rs1_val, 0);
        cycle(32'h0, 0, 0, 5'd0, 32'h0, st, is, ird);
        lat = de_latch_t'(DE_latch_out);
        check("bubble_valid", lat.valid, 0);

        reset_now();
        cur = gen_inst();
        for (int n = 0; n < 2500; n++) begin
            we = 1'b0; wrd = 5'd0; wdat = 32'h0;
            if (wbq.size() > 0 && wbq[0].due <= n) begin
                we = 1'b1;
                wrd = wbq[0].rd;
                wdat = $urandom;
                void'(wbq.pop_front());
            end
            fl = ($urandom_range(0, 15) == 0);
            cycle(cur, fl, we, wrd, wdat, st, is, ird);
            if (is && ird != 5'd0) wbq.push_back('{rd: ird, due: n + int'($urandom_range(1, 4))});
            if (!st) cur = gen_inst();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
